adc_frame_scheduler: RTL and testbench

- Sequences the MCP3202 SPI conversion engine: on a fixed sample-rate tick it requests a CH0 conversion, then a CH1 conversion, and publishes both as a left/right audio frame.
- Converts 12-bit offset-binary ADC codes to signed AUDIO_BIT_WIDTH samples.
- Sits between the SPI ADC core and the audio output path. Detects missed ticks (overrun) and hung conversions (timeout).

---
 rtl/adc_frame_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_adc_frame_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: paces MCP3202 conversions on a sample tick
// and publishes CH0/CH1 as a signed left/right audio frame.
module adc_frame_scheduler #(
    parameter int SAMPLE_DIV      = 3000,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       mono,
    input  logic                       clear_err,
    output logic                       adc_req,
    output logic                       adc_odd,
    input  logic                       adc_ack,
    input  logic                       adc_valid,
    input  logic [11:0]                adc_data,
    output logic [AUDIO_BIT_WIDTH-1:0] audio_left,
    output logic [AUDIO_BIT_WIDTH-1:0] audio_right,
    output logic                       sample_strobe,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        PUBLISH
    } state_t;

    state_t state;
    state_t state_n;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    logic          ch;
    logic          mono_f;
    logic [1:0][11:0] hold;
    logic [1:0][11:0] hold_n;

    logic start_frame;
    logic enter_req;
    logic advance_ch;
    logic capture;
    logic publish;
    logic tmo_fire;
    logic ovr_set;

    logic [AUDIO_BIT_WIDTH-1:0] left_n;
    logic [AUDIO_BIT_WIDTH-1:0] right_n;

    // Offset-binary to two's complement, left-justified in the sample.
    function automatic logic [AUDIO_BIT_WIDTH-1:0] to_audio(
        input logic [11:0] d
    );
        logic [AUDIO_BIT_WIDTH-1:0] s;
        s = '0;
        s[AUDIO_BIT_WIDTH-1 -: 12] = {~d[11], d[10:0]};
        return s;
    endfunction

    assign tick    = (tick_cnt == TICK_LAST);
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign ovr_set = tick && (state != IDLE);

    // Free-running sample-rate divider, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, handshake outputs and datapath controls.
    always_comb begin
        state_n       = state;
        adc_req       = 1'b0;
        adc_odd       = 1'b0;
        sample_strobe = 1'b0;
        start_frame   = 1'b0;
        enter_req     = 1'b0;
        advance_ch    = 1'b0;
        capture       = 1'b0;
        publish       = 1'b0;
        tmo_fire      = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick && enable) begin
                    state_n     = REQ;
                    start_frame = 1'b1;
                    enter_req   = 1'b1;
                end
            end
            REQ: begin
                adc_req = 1'b1;
                adc_odd = ch;
                if (tmo_hit) begin
                    state_n  = IDLE;
                    tmo_fire = 1'b1;
                end else if (adc_ack) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                adc_odd = ch;
                if (tmo_hit) begin
                    state_n  = IDLE;
                    tmo_fire = 1'b1;
                end else if (adc_valid) begin
                    capture = 1'b1;
                    if (!ch && !mono_f) begin
                        state_n    = REQ;
                        enter_req  = 1'b1;
                        advance_ch = 1'b1;
                    end else begin
                        state_n = PUBLISH;
                        publish = 1'b1;
                    end
                end
            end
            PUBLISH: begin
                sample_strobe = 1'b1;
                state_n       = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Conversion watchdog, restarted on every entry to REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (enter_req) begin
            tmo_cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Frame context: mono mode latched at frame start, channel pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            mono_f <= 1'b0;
            ch     <= 1'b0;
        end else if (start_frame) begin
            mono_f <= mono;
            ch     <= 1'b0;
        end else if (advance_ch) begin
            ch <= 1'b1;
        end
    end

    // Holding view including the sample arriving this cycle.
    always_comb begin
        hold_n = hold;
        if (capture) begin
            hold_n[ch] = adc_data;
        end
        left_n  = to_audio(hold_n[0]);
        right_n = to_audio(mono_f ? hold_n[0] : hold_n[1]);
    end

    // Per-channel holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (capture) begin
            hold <= hold_n;
        end
    end

    // Audio outputs load on the edge entering PUBLISH.
    always_ff @(posedge clk) begin
        if (reset) begin
            audio_left  <= '0;
            audio_right <= '0;
        end else if (publish) begin
            audio_left  <= left_n;
            audio_right <= right_n;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (tmo_fire) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb_adc_frame_scheduler: behavioural SPI engine plus frame
// scoreboard around adc_frame_scheduler.
module tb_adc_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mono = 1'b0;
    logic        clear_err = 1'b0;
    logic        adc_ack = 1'b0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_req;
    logic        adc_odd;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        sample_strobe;
    logic        overrun;
    logic        timeout_err;

    adc_frame_scheduler #(
        .SAMPLE_DIV     (16),
        .AUDIO_BIT_WIDTH(16),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mono         (mono),
        .clear_err    (clear_err),
        .adc_req      (adc_req),
        .adc_odd      (adc_odd),
        .adc_ack      (adc_ack),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .audio_left   (audio_left),
        .audio_right  (audio_right),
        .sample_strobe(sample_strobe),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tb_cnt = 0;
    always @(posedge clk) begin
        if (reset) tb_cnt <= 0;
        else tb_cnt <= (tb_cnt == 15) ? 0 : tb_cnt + 1;
    end

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          c;
    } exp_t;

    exp_t sb[$];

    int          ack_dly = 2;
    int          val_dly = 2;
    bit          hang = 1'b0;
    logic [11:0] d0 = '0;
    logic [11:0] d1 = '0;
    logic [15:0] e0 = '0;
    logic [15:0] e1 = '0;
    bit          eng_busy = 1'b0;
    bit          eng_wait = 1'b0;
    bit          eng_pre = 1'b0;
    bit          next_ch = 1'b0;
    logic        eng_ch = 1'b0;

    // SPI engine model: ack after ack_dly, result val_dly after ack.
    initial begin
        exp_t ent;
        forever begin
            @(posedge clk); #1;
            if (adc_req) begin
                eng_busy = 1'b1;
                eng_ch   = adc_odd;
                chk("adc_odd", 32'(adc_odd),
                    32'(mono ? 1'b0 : next_ch));
                for (int k = 0; k < ack_dly; k++) begin
                    @(posedge clk); #1;
                end
                adc_ack = 1'b1;
                @(posedge clk); #1;
                adc_ack = 1'b0;
                if (!hang) begin
                    eng_wait = 1'b1;
                    for (int k = 0; k < val_dly - 1; k++) begin
                        eng_pre = (k == val_dly - 2);
                        @(posedge clk); #1;
                    end
                    eng_pre   = 1'b0;
                    adc_valid = 1'b1;
                    adc_data  = eng_ch ? d1 : d0;
                    if (!reset) begin
                        if (eng_ch || mono) begin
                            ent.l = e0;
                            ent.r = mono ? e0 : e1;
                            ent.c = cyc + 1;
                            sb.push_back(ent);
                            next_ch = 1'b0;
                        end else begin
                            next_ch = 1'b1;
                        end
                    end
                    @(posedge clk); #1;
                    adc_valid = 1'b0;
                    eng_wait  = 1'b0;
                end
                eng_busy = 1'b0;
            end
        end
    end

    int   n_strobe = 0;
    exp_t got_e;

    // Frame monitor: every strobe must match a queued expectation.
    always @(negedge clk) begin
        if (sample_strobe) begin
            n_strobe++;
            if (sb.size() == 0) begin
                chk("strobe_unexpected", 32'(sample_strobe), 32'(0));
            end else begin
                got_e = sb.pop_front();
                chk("left", 32'(audio_left), 32'(got_e.l));
                chk("right", 32'(audio_right), 32'(got_e.r));
                chk("strobe_cyc", 32'(cyc), 32'(got_e.c));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(adc_req), 32'(0));
        chk({tag, "_odd"}, 32'(adc_odd), 32'(0));
        chk({tag, "_left"}, 32'(audio_left), 32'(0));
        chk({tag, "_right"}, 32'(audio_right), 32'(0));
        chk({tag, "_strobe"}, 32'(sample_strobe), 32'(0));
        chk({tag, "_ovr"}, 32'(overrun), 32'(0));
        chk({tag, "_tmo"}, 32'(timeout_err), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int ns;
        int k;
        int nreq;
        int rc;

        step(3);
        chk_zero("rst");
        reset = 1'b0;

        // stereo: 0xFFF / 0x000
        d0 = 12'hFFF; e0 = 16'h7FF0;
        d1 = 12'h000; e1 = 16'h8000;
        enable = 1'b1;
        step(40);
        ns = n_strobe;
        step(64);
        chk("stereo_rate", 32'(n_strobe - ns), 32'(4));
        chk("stereo_ovr", 32'(overrun), 32'(0));

        // mono: 0x800
        enable = 1'b0;
        step(40);
        mono = 1'b1;
        d0 = 12'h800; e0 = 16'h0000;
        enable = 1'b1;
        step(40);
        ns = n_strobe;
        step(64);
        chk("mono_rate", 32'(n_strobe - ns), 32'(4));

        // enable dropped during CH0 wait
        enable = 1'b0;
        step(40);
        mono = 1'b0;
        d0 = 12'h3A5; e0 = 16'hBA50;
        d1 = 12'hC5A; e1 = 16'h45A0;
        enable = 1'b1;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (eng_wait && eng_ch == 1'b0) break;
        end
        chk("drop_find_wait", 32'(k < 40), 32'(1));
        enable = 1'b0;
        ns = n_strobe;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (n_strobe != ns) break;
        end
        chk("drop_publish", 32'(k < 40), 32'(1));
        nreq = 0;
        repeat (40) begin
            step(1);
            if (adc_req) nreq++;
        end
        chk("drop_noreq", 32'(nreq), 32'(0));
        chk("drop_strobes", 32'(n_strobe - ns), 32'(1));
        enable = 1'b1;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (adc_req) break;
        end
        chk("resume_req", 32'(k < 40), 32'(1));
        chk("resume_phase", 32'(tb_cnt), 32'(0));

        // overrun with slow engine
        enable = 1'b0;
        step(40);
        chk("ovr_pre", 32'(overrun), 32'(0));
        d0 = 12'h123; e0 = 16'h9230;
        d1 = 12'hABC; e1 = 16'h2BC0;
        val_dly = 20;
        ns = n_strobe;
        enable = 1'b1;
        for (k = 0; k < 200; k++) begin
            step(1);
            if (tb_cnt == 15 && eng_busy) break;
        end
        chk("ovr_find_miss", 32'(k < 200), 32'(1));
        step(1);
        chk("ovr_set", 32'(overrun), 32'(1));
        for (k = 0; k < 300; k++) begin
            step(1);
            if (n_strobe >= ns + 2) break;
        end
        chk("ovr_frames", 32'(k < 300), 32'(1));
        for (k = 0; k < 40; k++) begin
            step(1);
            if (tb_cnt == 3) break;
        end
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'(0));
        for (k = 0; k < 200; k++) begin
            step(1);
            if (tb_cnt == 15 && eng_busy) break;
        end
        chk("ovr_find_miss2", 32'(k < 200), 32'(1));
        step(1);
        chk("ovr_again", 32'(overrun), 32'(1));
        for (k = 0; k < 200; k++) begin
            step(1);
            if (tb_cnt == 15 && eng_busy) break;
        end
        chk("ovr_find_miss3", 32'(k < 200), 32'(1));
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk("ovr_coincide", 32'(overrun), 32'(1));

        // hung conversion
        enable = 1'b0;
        step(100);
        val_dly = 2;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (tb_cnt == 3) break;
        end
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk("pre_to_ovr", 32'(overrun), 32'(0));
        chk("pre_to_tmo", 32'(timeout_err), 32'(0));
        hang = 1'b1;
        enable = 1'b1;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (adc_req) break;
        end
        chk("to_find_req", 32'(k < 40), 32'(1));
        rc = cyc;
        for (k = 0; k < 60; k++) begin
            step(1);
            if (timeout_err) break;
        end
        chk("to_fire", 32'(k < 60), 32'(1));
        chk("to_latency", 32'(cyc - rc), 32'(32));
        chk("to_req_low", 32'(adc_req), 32'(0));
        chk("to_left_kept", 32'(audio_left), 32'(16'h9230));
        chk("to_right_kept", 32'(audio_right), 32'(16'h2BC0));
        hang = 1'b0;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (adc_req) break;
        end
        chk("to_restart", 32'(k < 40), 32'(1));
        chk("to_restart_phase", 32'(tb_cnt), 32'(0));
        chk("to_ovr_sticky", 32'(overrun), 32'(1));
        chk("to_tmo_sticky", 32'(timeout_err), 32'(1));
        enable = 1'b0;
        step(30);
        for (k = 0; k < 40; k++) begin
            step(1);
            if (tb_cnt == 3) break;
        end
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        chk("to_clear_ovr", 32'(overrun), 32'(0));
        chk("to_clear_tmo", 32'(timeout_err), 32'(0));

        // reset in CH0 wait, result arrives next cycle
        val_dly = 4;
        enable = 1'b1;
        for (k = 0; k < 60; k++) begin
            step(1);
            if (eng_pre && eng_ch == 1'b0) break;
        end
        chk("rst_find_wait", 32'(k < 60), 32'(1));
        reset = 1'b1;
        enable = 1'b0;
        step(1);
        chk_zero("midrst");
        step(1);
        reset = 1'b0;
        ns = n_strobe;
        step(40);
        chk("midrst_nostrobe", 32'(n_strobe - ns), 32'(0));

        // normal operation after reset
        val_dly = 2;
        d0 = 12'h000; e0 = 16'h8000;
        d1 = 12'hFFF; e1 = 16'h7FF0;
        enable = 1'b1;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (adc_req) break;
        end
        chk("post_rst_req", 32'(k < 40), 32'(1));
        chk("post_rst_phase", 32'(tb_cnt), 32'(0));
        ns = n_strobe;
        for (k = 0; k < 40; k++) begin
            step(1);
            if (n_strobe != ns) break;
        end
        chk("post_rst_publish", 32'(k < 40), 32'(1));
        enable = 1'b0;
        step(30);
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
